// File: rtl/ym_phase_slot_seq_if.sv
// Sequencer control/status bundle: hold/resync requests in, phase enables and slot status out.
// Latency and backpressure are defined by the sequencer; this interface only carries the signals.
interface ym_phase_slot_seq_if #(
    parameter int SLOT_W = 5
);
    logic              hold;
    logic              resync;
    logic              c1;
    logic              c2;
    logic [SLOT_W-1:0] slot;
    logic              slot_last;
    logic              sync_out;
    logic              running;

    modport master (
        input  hold, resync,
        output c1, c2, slot, slot_last, sync_out, running
    );

    modport slave (
        output hold, resync,
        input  c1, c2, slot, slot_last, sync_out, running
    );
endinterface

// File: rtl/ym_phase_slot_seq.sv
// Two-phase c1/c2 enable sequencer with operator slot counter and sample-boundary strobe.
// Latency: outputs decode registered state only; backpressure: hold freezes cnt/slot, resync realigns.
module ym_phase_slot_seq #(
    parameter int PHASE_LEN = 3,
    parameter int SLOTS     = 24,
    parameter int SLOT_W    = 5
) (
    input  logic                  MCLK,
    input  logic                  reset,
    ym_phase_slot_seq_if.master   bus
);
    localparam int CNT_W = (2 * PHASE_LEN > 2) ? $clog2(2 * PHASE_LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(2 * PHASE_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_PH2  = CNT_W'(PHASE_LEN);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SLOTS - 1);

    // ST_IDLE is run=0, ST_HOLD is run=1 with hold_q=1.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              run, hold_q, phase_en;

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            slot_q <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            slot_q <= slot_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        slot_d  = slot_q;
        if (bus.resync) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            slot_d  = '0;
        end else if (state == ST_IDLE) begin
            state_d = ST_RUN;
        end else if (bus.hold) begin
            state_d = ST_HOLD;
        end else begin
            state_d = ST_RUN;
            if (cnt == CNT_MAX) begin
                cnt_d  = '0;
                slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + SLOT_W'(1);
            end else begin
                cnt_d  = cnt + CNT_W'(1);
            end
        end
    end

    assign run      = (state != ST_IDLE);
    assign hold_q   = (state == ST_HOLD);
    assign phase_en = run & ~hold_q;

    assign bus.c1        = phase_en & (cnt == '0);
    assign bus.c2        = phase_en & (cnt == CNT_PH2);
    assign bus.sync_out  = bus.c1 & (slot_q == '0);
    assign bus.slot_last = run & (slot_q == SLOT_MAX);
    assign bus.slot      = slot_q;
    assign bus.running   = phase_en;
endmodule

// File: tb/tb_ym_phase_slot_seq.sv
// Bench for ym_phase_slot_seq: default instance (3/24) plus a PHASE_LEN=1, SLOTS=4 instance.
// A reference model queues the expected outputs for each edge; directed checks cover timing landmarks.
module tb_ym_phase_slot_seq;
    logic MCLK  = 1'b0;
    logic reset = 1'b1;
    always #5 MCLK = ~MCLK;

    ym_phase_slot_seq_if #(.SLOT_W(5)) bus0 ();
    ym_phase_slot_seq_if #(.SLOT_W(2)) bus1 ();

    ym_phase_slot_seq #(.PHASE_LEN(3), .SLOTS(24), .SLOT_W(5)) dut0 (
        .MCLK  (MCLK),
        .reset (reset),
        .bus   (bus0)
    );

    ym_phase_slot_seq #(.PHASE_LEN(1), .SLOTS(4), .SLOT_W(2)) dut1 (
        .MCLK  (MCLK),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct packed {
        logic       c1;
        logic       c2;
        logic [4:0] slot;
        logic       slot_last;
        logic       sync_out;
        logic       running;
    } out_t;

    typedef struct packed {
        int   cnt;
        int   slot;
        logic run;
        logic hq;
    } ms_t;

    ms_t  m0, m1;
    out_t q0[$];
    out_t q1[$];
    out_t o0, o1, e;
    int   n_chk = 0;
    int   n_bad = 0;
    int   kc;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic ms_t step(input ms_t s, input logic rst, input logic h, input logic r,
                                 input int plen, input int slots);
        ms_t n = s;
        if (rst) begin
            n = '0;
        end else if (r) begin
            n.cnt = 0; n.slot = 0; n.run = 1'b1; n.hq = 1'b0;
        end else if (!s.run) begin
            n.run = 1'b1;
        end else if (h) begin
            n.hq = 1'b1;
        end else begin
            n.hq = 1'b0;
            if (s.cnt == 2 * plen - 1) begin
                n.cnt  = 0;
                n.slot = (s.slot == slots - 1) ? 0 : s.slot + 1;
            end else begin
                n.cnt = s.cnt + 1;
            end
        end
        return n;
    endfunction

    function automatic out_t outs(input ms_t s, input int plen, input int slots);
        out_t o = '0;
        o.running   = s.run && !s.hq;
        o.c1        = o.running && (s.cnt == 0);
        o.c2        = o.running && (s.cnt == plen);
        o.sync_out  = o.c1 && (s.slot == 0);
        o.slot_last = s.run && (s.slot == slots - 1);
        o.slot      = 5'(s.slot);
        return o;
    endfunction

    function automatic out_t obs0();
        return {bus0.c1, bus0.c2, bus0.slot, bus0.slot_last, bus0.sync_out, bus0.running};
    endfunction

    function automatic out_t obs1();
        return {bus1.c1, bus1.c2, 3'b000, bus1.slot, bus1.slot_last, bus1.sync_out, bus1.running};
    endfunction

    task automatic set_in(input logic h, input logic r);
        bus0.hold = h; bus1.hold = h;
        bus0.resync = r; bus1.resync = r;
    endtask

    // Model advances on the same edge as the DUTs; compare 1 time unit later.
    task automatic tick();
        @(posedge MCLK);
        m0 = step(m0, reset, bus0.hold, bus0.resync, 3, 24);
        m1 = step(m1, reset, bus1.hold, bus1.resync, 1, 4);
        q0.push_back(outs(m0, 3, 24));
        q1.push_back(outs(m1, 1, 4));
        #1;
        kc++;
        o0 = obs0();
        o1 = obs1();
        e = q0.pop_front();
        check_val("sb0", o0, e);
        e = q1.pop_front();
        check_val("sb1", o1, e);
    endtask

    task automatic seek(input int s, input int c);
        for (int i = 0; i < 400 && !(m0.slot == s && m0.cnt == c); i++) tick();
        check_val("seek", (m0.slot == s && m0.cnt == c), 1);
    endtask

    initial begin
        int last0, last1, sl_cnt, maxs;
        set_in(1'b0, 1'b0);
        m0 = '0;
        m1 = '0;
        kc = 0;
        #2;
        check_val("rst_out0", obs0(), 0);
        check_val("rst_out1", obs1(), 0);
        repeat (3) tick();

        // Startup and free-running behaviour.
        reset = 1'b0;
        kc = -1;
        last0 = -1; last1 = -1; sl_cnt = 0; maxs = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (kc == 0) begin
                check_val("first_c1", o0.c1, 1);
                check_val("first_slot", o0.slot, 0);
                check_val("first_sync", o0.sync_out, 1);
            end
            if (kc == 3) check_val("c2_at3", o0.c2, 1);
            if (kc == 6) begin
                check_val("c1_at6", o0.c1, 1);
                check_val("slot_at6", o0.slot, 1);
            end
            if (int'(o0.slot) > maxs) maxs = int'(o0.slot);
            if (o0.slot_last) sl_cnt++;
            if (o0.sync_out) begin
                check_val("sync_c1", o0.c1, 1);
                check_val("sync_slot0", o0.slot, 0);
                if (last0 >= 0) begin
                    check_val("sync_period", kc - last0, 144);
                    check_val("slot_last_cnt", sl_cnt, 6);
                end
                last0 = kc;
                sl_cnt = 0;
            end
            check_val("c1c2_excl", o0.c1 & o0.c2, 0);
            check_val("alt1", o1.c1 ^ o1.c2, 1);
            if (kc % 2 == 0) check_val("slot1", o1.slot, (kc / 2) % 4);
            if (o1.sync_out) begin
                if (last1 >= 0) check_val("sync1_period", kc - last1, 8);
                last1 = kc;
            end
        end
        check_val("slot_max", maxs, 23);

        // Hold at cnt=2, slot=5 for 10 cycles.
        seek(5, 2);
        check_val("pre_hold_slot", o0.slot, 5);
        set_in(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("hold_c1", o0.c1, 0);
            check_val("hold_c2", o0.c2, 0);
            check_val("hold_running", o0.running, 0);
            check_val("hold_slot", o0.slot, 5);
        end
        set_in(1'b0, 1'b0);
        tick();
        check_val("unhold_c2", o0.c2, 1);
        check_val("unhold_slot", o0.slot, 5);

        // Resync alone, then together with hold.
        seek(17, 4);
        set_in(1'b0, 1'b1);
        tick();
        check_val("rsync_c1", o0.c1, 1);
        check_val("rsync_slot", o0.slot, 0);
        check_val("rsync_sync", o0.sync_out, 1);
        set_in(1'b0, 1'b0);
        repeat (5) tick();
        set_in(1'b1, 1'b1);
        tick();
        check_val("rsh_c1", o0.c1, 1);
        check_val("rsh_sync", o0.sync_out, 1);
        check_val("rsh_running", o0.running, 1);
        set_in(1'b1, 1'b0);
        tick();
        check_val("rsh_held", o0.running, 0);
        set_in(1'b0, 1'b0);
        repeat (3) tick();

        // Asynchronous reset between edges at slot 9, cnt 3.
        seek(9, 3);
        #2;
        reset = 1'b1;
        m0 = '0;
        m1 = '0;
        #1;
        check_val("arst_out0", obs0(), 0);
        check_val("arst_out1", obs1(), 0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check_val("rec_c1", o0.c1, 1);
        check_val("rec_slot", o0.slot, 0);
        check_val("rec_sync", o0.sync_out, 1);
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
